// File: rtl/ucsbece154b_icache.sv
// Set-associative read-only instruction cache with round-robin replacement.
// Lookup is combinational on the latched request; misses fetch a whole block in order.
module ucsbece154b_icache #(
    parameter int NUM_SETS    = 8,
    parameter int NUM_WAYS    = 4,
    parameter int BLOCK_WORDS = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ReadEnable_i,
    input  logic [31:0] ReadAddress_i,
    output logic [31:0] Instruction_o,
    output logic        Ready_o,
    output logic        Busy_o,
    output logic        MemReadRequest_o,
    output logic [31:0] MemReadAddress_o,
    input  logic [31:0] MemDataIn_i,
    input  logic        MemDataReady_i
);

    // state | meaning
    // IDLE  | lookup of latched request; hit answers this cycle
    // REQ   | block read request issued, victim way chosen
    // FILL  | block words arriving in order, written to victim way
    // RESP  | requested word returned; new request may be accepted

    localparam int WO    = $clog2(BLOCK_WORDS);
    localparam int SI    = $clog2(NUM_SETS);
    localparam int WW    = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
    localparam int TAG_W = 32 - SI - WO - 2;

    typedef enum logic [1:0] {IDLE, REQ, FILL, RESP} stateType;

    stateType          state;
    logic              reqValid;
    logic [31:2]       reqAddr;
    logic              memReq;
    logic [31:0]       memAddr;
    logic [WW-1:0]     victimWay;
    logic              rrUsed;
    logic [WO-1:0]     wordCnt;
    logic [31:0]       respWord;
    logic [31:0]       lastInstr;

    logic [NUM_WAYS-1:0] validBits [NUM_SETS];
    logic [WW-1:0]       rrPtr     [NUM_SETS];
    logic [TAG_W-1:0]    tagArr    [NUM_SETS][NUM_WAYS];
    logic [31:0]         dataArr   [NUM_SETS][NUM_WAYS][BLOCK_WORDS];

    logic [WO-1:0]    reqOffset;
    logic [SI-1:0]    reqSet;
    logic [TAG_W-1:0] reqTag;
    logic             hit;
    logic [WW-1:0]    hitWay;
    logic             allValid;
    logic [WW-1:0]    victimSel;
    logic             lookupHit;
    logic             lookupMiss;
    logic             accept;
    logic             memWrite;
    logic             fillDone;
    logic [31:0]      outWord;
    logic             unusedAddrBits;

    assign unusedAddrBits = ^ReadAddress_i[1:0];

    assign reqOffset = reqAddr[WO+1:2];
    assign reqSet    = reqAddr[SI+WO+1:WO+2];
    assign reqTag    = reqAddr[31:SI+WO+2];

    always_comb begin
        hit       = 1'b0;
        hitWay    = '0;
        allValid  = &validBits[reqSet];
        victimSel = rrPtr[reqSet];
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (validBits[reqSet][WW'(w)] && (tagArr[reqSet][WW'(w)] == reqTag)) begin
                hit    = 1'b1;
                hitWay = WW'(w);
            end
        end
        // Walk downwards so the lowest-index invalid way wins.
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (!validBits[reqSet][WW'(w)]) begin
                victimSel = WW'(w);
            end
        end
    end

    assign lookupHit  = (state == IDLE) && reqValid && hit;
    assign lookupMiss = (state == IDLE) && reqValid && !hit;
    assign Ready_o    = lookupHit || (state == RESP);
    assign Busy_o     = lookupMiss || (state == REQ) || (state == FILL);
    assign accept     = ReadEnable_i && !Busy_o;
    assign memWrite   = (state == FILL) && MemDataReady_i;
    assign fillDone   = memWrite && (wordCnt == WO'(BLOCK_WORDS - 1));

    assign outWord       = (state == RESP) ? respWord : dataArr[reqSet][hitWay][reqOffset];
    assign Instruction_o = Ready_o ? outWord : lastInstr;

    assign MemReadRequest_o = memReq;
    assign MemReadAddress_o = memAddr;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            reqValid  <= 1'b0;
            reqAddr   <= '0;
            memReq    <= 1'b0;
            memAddr   <= '0;
            victimWay <= '0;
            rrUsed    <= 1'b0;
            wordCnt   <= '0;
            respWord  <= '0;
            lastInstr <= '0;
            for (int s = 0; s < NUM_SETS; s++) begin
                validBits[s] <= '0;
                rrPtr[s]     <= '0;
            end
        end else begin
            reqValid <= accept;
            if (accept) begin
                reqAddr <= ReadAddress_i[31:2];
            end
            if (Ready_o) begin
                lastInstr <= outWord;
            end
            memReq <= 1'b0;
            case (state)
                IDLE: begin
                    if (lookupMiss) begin
                        state   <= REQ;
                        memReq  <= 1'b1;
                        memAddr <= {reqTag, reqSet, {WO{1'b0}}, 2'b00};
                    end
                end
                REQ: begin
                    victimWay <= victimSel;
                    rrUsed    <= allValid;
                    wordCnt   <= '0;
                    state     <= FILL;
                end
                FILL: begin
                    if (MemDataReady_i) begin
                        wordCnt <= wordCnt + WO'(1);
                        if (wordCnt == reqOffset) begin
                            respWord <= MemDataIn_i;
                        end
                        // Valid is set only now, so a partially filled way never hits.
                        if (fillDone) begin
                            validBits[reqSet][victimWay] <= 1'b1;
                            if (rrUsed) begin
                                rrPtr[reqSet] <= rrPtr[reqSet] + WW'(1);
                            end
                            state <= RESP;
                        end
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && memWrite) begin
            dataArr[reqSet][victimWay][wordCnt] <= MemDataIn_i;
            if (fillDone) begin
                tagArr[reqSet][victimWay] <= reqTag;
            end
        end
    end

endmodule
